// File: rtl/cpu_top.sv
// Accumulator CPU: 16-bit ACC, 8-bit PC, four-state FETCH/EXEC/MEM/HALT sequencer.
// Latency: 1 cycle for register/jump ops, 2 cycles for memory-operand ops and STORE.
// Backpressure: none; assumes a synchronous memory answering on every cycle.
//
// Ports:
//   clk      : clock, all state updates on the rising edge
//   rst_n    : synchronous reset, active HIGH despite the name
//   data_in  : memory read data, mem[address of the previous cycle]
//   address  : memory address, combinational from state/PC/IR/data_in
//   data_out : write data, mirrors ACC (forced to 0 while reset is asserted)
//   wea      : write strobe, high only in the EXEC cycle of a STORE
module cpu_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    output logic [7:0]  address,
    output logic [15:0] data_out,
    output logic        wea
);
    localparam logic [7:0] OPCODE_HALT   = 8'h00;
    localparam logic [7:0] OPCODE_LOAD   = 8'h01;
    localparam logic [7:0] OPCODE_STORE  = 8'h02;
    localparam logic [7:0] OPCODE_ADD    = 8'h03;
    localparam logic [7:0] OPCODE_SUB    = 8'h04;
    localparam logic [7:0] OPCODE_AND    = 8'h05;
    localparam logic [7:0] OPCODE_OR     = 8'h06;
    localparam logic [7:0] OPCODE_NOT    = 8'h07;
    localparam logic [7:0] OPCODE_SHL    = 8'h08;
    localparam logic [7:0] OPCODE_SHR    = 8'h09;
    localparam logic [7:0] OPCODE_JMP    = 8'h0A;
    localparam logic [7:0] OPCODE_JMPGEZ = 8'h0B;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  addr_q;        // last driven address, replayed while halted
    logic [7:0]  next_addr;     // fetch-slot address (jump target or PC)

    logic [7:0] in_opc;
    logic [7:0] in_opd;
    assign in_opc = data_in[15:8];
    assign in_opd = data_in[7:0];

    // The operand byte is latched with the opcode but only the opcode is
    // needed once the memory operand cycle is running.
    logic ir_operand_unused;
    assign ir_operand_unused = ^ir_q[7:0];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        address   = addr_q;
        wea       = 1'b0;
        next_addr = pc_q;

        case (state_q)
            S_FETCH: begin
                address = pc_q;
                pc_d    = pc_q + 8'd1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // data_in is the instruction fetched last cycle; decode it
                // directly so memory-operand and jump addresses go out now.
                ir_d = data_in;
                case (in_opc)
                    OPCODE_LOAD, OPCODE_ADD, OPCODE_SUB, OPCODE_AND, OPCODE_OR: begin
                        address = in_opd;
                        state_d = S_MEM;
                    end
                    OPCODE_STORE: begin
                        address = in_opd;
                        wea     = 1'b1;
                        state_d = S_FETCH;
                    end
                    OPCODE_HALT: begin
                        address = pc_q;
                        state_d = S_HALT;
                    end
                    default: begin
                        // Fetch slot: the next instruction is fetched in this
                        // same cycle, so these ops cost a single cycle.
                        if ((in_opc == OPCODE_JMP) ||
                            ((in_opc == OPCODE_JMPGEZ) && !acc_q[15])) begin
                            next_addr = in_opd;
                        end
                        case (in_opc)
                            OPCODE_NOT: acc_d = ~acc_q;
                            OPCODE_SHL: acc_d = {acc_q[14:0], 1'b0};
                            OPCODE_SHR: acc_d = {acc_q[15], acc_q[15:1]};
                            default:    acc_d = acc_q;
                        endcase
                        address = next_addr;
                        pc_d    = next_addr + 8'd1;
                        state_d = S_EXEC;
                    end
                endcase
            end
            S_MEM: begin
                // data_in is the operand; this cycle also fetches the next
                // instruction from PC.
                case (ir_q[15:8])
                    OPCODE_LOAD: acc_d = data_in;
                    OPCODE_ADD:  acc_d = acc_q + data_in;
                    OPCODE_SUB:  acc_d = acc_q - data_in;
                    OPCODE_AND:  acc_d = acc_q & data_in;
                    OPCODE_OR:   acc_d = acc_q | data_in;
                    default:     acc_d = acc_q;
                endcase
                address = pc_q;
                pc_d    = pc_q + 8'd1;
                state_d = S_EXEC;
            end
            S_HALT: begin
                address = addr_q;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset wins combinationally so a STORE caught by reset never writes.
        if (rst_n) begin
            address = 8'd0;
            wea     = 1'b0;
        end
    end

    assign data_out = rst_n ? 16'd0 : acc_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_FETCH;
            acc_q   <= 16'd0;
            ir_q    <= 16'd0;
            pc_q    <= 8'd0;
            addr_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            addr_q  <= address;
        end
    end
endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: synchronous memory, instruction-level reference model,
// per-cycle output compare, plus literal checks on program results.
module tb_cpu_top;
    localparam logic [7:0] OP_HALT   = 8'h00;
    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_STORE  = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_AND    = 8'h05;
    localparam logic [7:0] OP_OR     = 8'h06;
    localparam logic [7:0] OP_NOT    = 8'h07;
    localparam logic [7:0] OP_SHL    = 8'h08;
    localparam logic [7:0] OP_SHR    = 8'h09;
    localparam logic [7:0] OP_JMP    = 8'h0A;
    localparam logic [7:0] OP_JMPGEZ = 8'h0B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic [7:0]  address;
    logic [15:0] data_out;
    logic        wea;

    cpu_top dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .address  (address),
        .data_out (data_out),
        .wea      (wea)
    );

    always #5 clk = ~clk;

    // ---------------- synchronous memory ----------------
    logic [15:0] mem [256];
    always @(posedge clk) begin
        data_in <= mem[address];
        if (wea) mem[address] = data_out;
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    int run_cycle = 0;
    int n_writes = 0;
    int w54_count = 0;
    int w54_cycle = 0;
    int w80_count = 0;
    logic [15:0] w80_dat = 16'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    // Executes one instruction at a time and emits the per-cycle bus activity
    // (address, wea, data_out) that instruction must produce.
    typedef struct packed {
        logic [7:0]  a;
        logic        w;
        logic [15:0] d;
    } cyc_t;

    cyc_t        expq[$];
    logic [15:0] mmem [256];
    logic [7:0]  m_pc;
    logic [15:0] m_acc;
    bit          m_need_fetch;
    bit          m_halted;
    logic [7:0]  m_halt_addr;

    function automatic cyc_t mk(input logic [7:0] a, input logic w, input logic [15:0] d);
        cyc_t c;
        c.a = a; c.w = w; c.d = d;
        return c;
    endfunction

    task automatic model_reset();
        expq.delete();
        m_pc = 8'd0;
        m_acc = 16'd0;
        m_need_fetch = 1'b1;
        m_halted = 1'b0;
        m_halt_addr = 8'd0;
    endtask

    task automatic model_step();
        logic [15:0] ins;
        logic [7:0]  op, opd;
        logic [15:0] v;
        if (m_halted) begin
            expq.push_back(mk(m_halt_addr, 1'b0, m_acc));
            return;
        end
        if (m_need_fetch) expq.push_back(mk(m_pc, 1'b0, m_acc));
        ins = mmem[m_pc];
        m_pc = m_pc + 8'd1;
        op = ins[15:8];
        opd = ins[7:0];
        m_need_fetch = 1'b0;
        if (op == OP_LOAD || op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR) begin
            v = mmem[opd];
            expq.push_back(mk(opd, 1'b0, m_acc));
            expq.push_back(mk(m_pc, 1'b0, m_acc));
            case (op)
                OP_LOAD: m_acc = v;
                OP_ADD:  m_acc = 16'(m_acc + v);
                OP_SUB:  m_acc = 16'(m_acc - v);
                OP_AND:  m_acc = m_acc & v;
                default: m_acc = m_acc | v;
            endcase
        end else if (op == OP_STORE) begin
            expq.push_back(mk(opd, 1'b1, m_acc));
            mmem[opd] = m_acc;
            m_need_fetch = 1'b1;
        end else if (op == OP_HALT) begin
            expq.push_back(mk(m_pc, 1'b0, m_acc));
            m_halted = 1'b1;
            m_halt_addr = m_pc;
        end else begin
            logic [7:0] na;
            na = m_pc;
            if (op == OP_JMP || (op == OP_JMPGEZ && $signed(m_acc) >= 0)) na = opd;
            expq.push_back(mk(na, 1'b0, m_acc));
            if (op == OP_NOT) m_acc = ~m_acc;
            else if (op == OP_SHL) m_acc = 16'(m_acc * 2);
            else if (op == OP_SHR) m_acc = 16'($signed(m_acc) >>> 1);
            m_pc = na;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        cyc_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rst_address", 32'(address), 32'd0);
                chk("rst_wea", 32'(wea), 32'd0);
                chk("rst_data_out", 32'(data_out), 32'd0);
                model_reset();
                run_cycle = 0;
            end else begin
                if (expq.size() == 0) model_step();
                e = expq.pop_front();
                chk("cyc_address", 32'(address), 32'(e.a));
                chk("cyc_wea", 32'(wea), 32'(e.w));
                chk("cyc_data_out", 32'(data_out), 32'(e.d));
                if (wea) begin
                    n_writes++;
                    if (address == 8'd54) begin
                        w54_count++;
                        w54_cycle = run_cycle;
                    end
                    if (address == 8'h80) begin
                        w80_count++;
                        w80_dat = data_out;
                    end
                end
                run_cycle++;
            end
        end
    end

    // ---------------- program loaders ----------------
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'd0;
            mmem[i] = 16'd0;
        end
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] op, input logic [7:0] opd);
        mem[a] = {op, opd};
        mmem[a] = {op, opd};
    endtask

    task automatic put_data(input logic [7:0] a, input logic [15:0] v);
        mem[a] = v;
        mmem[a] = v;
    endtask

    task automatic load_sum();
        clear_mem();
        put_data(8'd50, 16'd0); put_data(8'd51, 16'd1);
        put_data(8'd52, 16'd1); put_data(8'd53, 16'd99);
        put(8'd0, OP_LOAD, 8'd50);  put(8'd1, OP_ADD, 8'd51);   put(8'd2, OP_STORE, 8'd50);
        put(8'd3, OP_LOAD, 8'd51);  put(8'd4, OP_ADD, 8'd52);   put(8'd5, OP_STORE, 8'd51);
        put(8'd6, OP_LOAD, 8'd53);  put(8'd7, OP_SUB, 8'd52);   put(8'd8, OP_STORE, 8'd53);
        put(8'd9, OP_JMPGEZ, 8'd0); put(8'd10, OP_LOAD, 8'd50); put(8'd11, OP_STORE, 8'd54);
        put(8'd12, OP_HALT, 8'd0);
    endtask

    task automatic load_alu();
        clear_mem();
        put_data(8'h20, 16'h7FFF); put_data(8'h21, 16'h0001); put_data(8'h22, 16'h0000);
        put_data(8'h23, 16'h8001); put_data(8'h24, 16'h0F0F); put_data(8'h25, 16'hF000);
        put_data(8'h26, 16'h1234);
        put(8'd0,  OP_LOAD, 8'h20);  put(8'd1,  OP_ADD, 8'h21);    put(8'd2,  OP_STORE, 8'h30);
        put(8'd3,  OP_LOAD, 8'h22);  put(8'd4,  OP_SUB, 8'h21);    put(8'd5,  OP_STORE, 8'h31);
        put(8'd6,  OP_JMPGEZ, 8'h00); put(8'd7, OP_STORE, 8'h32);  put(8'd8,  OP_LOAD, 8'h23);
        put(8'd9,  OP_SHR, 8'h00);   put(8'd10, OP_STORE, 8'h33);  put(8'd11, OP_SHL, 8'h00);
        put(8'd12, OP_STORE, 8'h34); put(8'd13, OP_NOT, 8'h00);    put(8'd14, OP_STORE, 8'h35);
        put(8'd15, OP_AND, 8'h24);   put(8'd16, OP_OR, 8'h25);     put(8'd17, 8'hFF, 8'h00);
        put(8'd18, OP_STORE, 8'h36); put(8'd19, OP_LOAD, 8'h26);   put(8'd20, OP_STORE, 8'h80);
        put(8'd21, OP_JMP, 8'h40);   put(8'd22, OP_STORE, 8'h3F);  put(8'd23, OP_HALT, 8'h00);
        put(8'h40, OP_LOAD, 8'h22);  put(8'h41, OP_JMPGEZ, 8'h50); put(8'h42, OP_HALT, 8'h00);
        put(8'h50, OP_NOT, 8'h00);   put(8'h51, OP_STORE, 8'h38);  put(8'h52, OP_HALT, 8'h00);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : stim
        bit seen;
        int wr_before;
        rst_n = 1'b1;
        load_sum();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("first_fetch_addr", 32'(address), 32'd0);

        // Reset landing on the first STORE (STORE 50, ACC=1) must suppress the write.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (wea) seen = 1'b1;
        end
        if (seen) begin
            chk("first_store_addr", 32'(address), 32'd50);
            chk("first_store_data", 32'(data_out), 32'd1);
            #1 rst_n = 1'b1;
            #1 chk("reset_kills_wea", 32'(wea), 32'd0);
            @(posedge clk);
            #1 chk("no_write_in_reset", 32'(mem[50]), 32'd0);
        end else begin
            chk("first_store_seen", 32'd0, 32'd1);
            rst_n = 1'b1;
            @(posedge clk);
        end

        // Full sum program.
        load_sum();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (1960) @(posedge clk);
        #1;
        chk("sum_result", 32'(mem[54]), 32'd5050);
        chk("sum_store_count", 32'(w54_count), 32'd1);
        chk("sum_deadline", 32'(w54_cycle < 1950), 32'd1);
        chk("sum_counter_final", 32'(mem[53]), 32'h0000FFFF);

        // Halted: no writes for 100 cycles (address stability is in the per-cycle compare).
        wr_before = n_writes;
        repeat (100) @(posedge clk);
        #1 chk("halt_no_writes", 32'(n_writes - wr_before), 32'd0);

        // Reset out of HALT, run the ALU / wrap / jump program.
        rst_n = 1'b1;
        @(posedge clk);
        #1 load_alu();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("restart_addr", 32'(address), 32'd0);
        chk("restart_acc", 32'(data_out), 32'd0);
        repeat (150) @(posedge clk);
        #1;
        chk("wrap_add", 32'(mem[8'h30]), 32'h8000);
        chk("wrap_sub", 32'(mem[8'h31]), 32'hFFFF);
        chk("jmpgez_not_taken", 32'(mem[8'h32]), 32'hFFFF);
        chk("shr_arith", 32'(mem[8'h33]), 32'hC000);
        chk("shl", 32'(mem[8'h34]), 32'h8000);
        chk("not", 32'(mem[8'h35]), 32'h7FFF);
        chk("and_or_nop", 32'(mem[8'h36]), 32'hFF0F);
        chk("store_mem80", 32'(mem[8'h80]), 32'h1234);
        chk("store_wea_cycles", 32'(w80_count), 32'd1);
        chk("store_data_out", 32'(w80_dat), 32'h1234);
        chk("jmp_skips", 32'(mem[8'h3F]), 32'h0000);
        chk("jmpgez_zero_taken", 32'(mem[8'h38]), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
